// File: rtl/regfile_sb.sv
// Parametrised register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module regfile_sb #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter int          NRD     = 2,
  parameter int          SP_IDX  = 2,
  parameter int unsigned SP_INIT = 512,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Allocate is applied after release so a new producer wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en && wr_addr != '0) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (alloc_en && alloc_addr != '0) begin
      busy_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX && i != 0)
                   ? XLEN'(SP_INIT) : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          nz;
    assign a  = rs_addr[k*AW +: AW];
    assign nz = a != '0;
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = !rst && wr_en && nz && (wr_addr == a);
    assign rs_data[k*XLEN +: XLEN] =
      !nz ? '0 : (hit ? wr_data : regs_q[a]);
    assign rs_busy[k] = nz &&
      (hit ? (alloc_en && alloc_addr == a) : busy_q[a]);
`else
    assign rs_data[k*XLEN +: XLEN] = nz ? regs_q[a] : '0;
    assign rs_busy[k] = nz && busy_q[a];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default build and a
// 16-reg / 3-port / 64-bit instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        a_rst = 1'b1;
  logic [9:0]  a_rs_addr = '0;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic        a_wr_en = 1'b0;
  logic [4:0]  a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic        a_alloc_en = 1'b0;
  logic [4:0]  a_alloc_addr = '0;
  logic [31:0] a_busy_vec;

  regfile_sb u_a (
    .clk(clk), .rst(a_rst),
    .rs_addr(a_rs_addr), .rs_data(a_rs_data),
    .rs_busy(a_rs_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr),
    .busy_vec(a_busy_vec)
  );

  // Wide instance
  logic         b_rst = 1'b1;
  logic [11:0]  b_rs_addr = '0;
  logic [191:0] b_rs_data;
  logic [2:0]   b_rs_busy;
  logic         b_wr_en = 1'b0;
  logic [3:0]   b_wr_addr = '0;
  logic [63:0]  b_wr_data = '0;
  logic         b_alloc_en = 1'b0;
  logic [3:0]   b_alloc_addr = '0;
  logic [15:0]  b_busy_vec;

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u_b (
    .clk(clk), .rst(b_rst),
    .rs_addr(b_rs_addr), .rs_data(b_rs_data),
    .rs_busy(b_rs_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr),
    .busy_vec(b_busy_vec)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          port;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int d, input int k, input int p,
                    input logic [63:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.kind = k;
    e.port = p; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic ard(input int p, input int r);
    a_rs_addr[p*5 +: 5] = 5'(r);
  endtask

  task automatic brd(input int p, input int r);
    b_rs_addr[p*4 +: 4] = 4'(r);
  endtask

  function automatic logic [63:0] actual(input exp_t e);
    logic [63:0] v;
    v = '0;
    if (e.dut == 0) begin
      case (e.kind)
        0: v = {32'b0, a_rs_data[e.port*32 +: 32]};
        1: v = {63'b0, a_rs_busy[e.port]};
        default: v = {32'b0, a_busy_vec};
      endcase
    end else begin
      case (e.kind)
        0: v = b_rs_data[e.port*64 +: 64];
        1: v = {63'b0, b_rs_busy[e.port]};
        default: v = {48'b0, b_busy_vec};
      endcase
    end
    return v;
  endfunction

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      act = actual(e);
      checks++;
      if (act !== e.exp || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got %h expected %h",
                 e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] byp;

  initial begin
    // Reset both instances
    step();
    a_rst = 1'b0;
    for (int r = 0; r < 32; r += 2) begin
      ard(0, r); ard(1, r + 1);
      ex(0, 0, 0, (r == 2) ? 64'd512 : 64'd0, "rst_data0");
      ex(0, 0, 1, 64'd0, "rst_data1");
      ex(0, 1, 0, 64'd0, "rst_busy0");
      ex(0, 1, 1, 64'd0, "rst_busy1");
      step();
    end
    ex(0, 2, 0, 64'd0, "rst_busyvec");

    // Write x5, then try writing x0
    a_wr_en = 1'b1; a_wr_addr = 5'd5;
    a_wr_data = 32'hDEADBEEF;
    step();
    a_wr_addr = 5'd0; a_wr_data = 32'h1234;
    ard(0, 5); ard(1, 5);
    ex(0, 0, 0, 64'hDEADBEEF, "wr_x5_p0");
    ex(0, 0, 1, 64'hDEADBEEF, "wr_x5_p1");
    step();
    a_wr_en = 1'b0;
    ard(0, 0); ard(1, 0);
    ex(0, 0, 0, 64'd0, "x0_data");
    ex(0, 1, 1, 64'd0, "x0_busy");

    // Scoreboard allocate / release on x7
    a_alloc_en = 1'b1; a_alloc_addr = 5'd7;
    step();
    a_alloc_en = 1'b0;
    ard(0, 5); ard(1, 7);
    ex(0, 1, 1, 64'd1, "x7_busy");
    ex(0, 1, 0, 64'd0, "x5_notbusy");
    ex(0, 2, 0, 64'h80, "x7_busyvec");
    step();
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h55;
    ard(1, 5);
    step();
    a_wr_en = 1'b0;
    ard(1, 7);
    ex(0, 0, 1, 64'h55, "x7_data");
    ex(0, 1, 1, 64'd0, "x7_released");
    ex(0, 2, 0, 64'd0, "x7_busyvec_clr");

    // Same-address write + allocate on x9
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hA5;
    a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
    step();
    a_wr_en = 1'b0;
    a_alloc_addr = 5'd10;
    ard(0, 9);
    ex(0, 0, 0, 64'hA5, "x9_data");
    ex(0, 1, 0, 64'd1, "x9_busy");
    ex(0, 2, 0, 64'h200, "x9_busyvec");
    step();
    // Alloc x9 again, write x10 in the same cycle
    a_alloc_addr = 5'd9;
    a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'hBB;
    ard(0, 5); ard(1, 9);
    ex(0, 2, 0, 64'h600, "x9x10_busyvec");
    ex(0, 1, 1, 64'd1, "x9_busy2");
    step();
    a_alloc_en = 1'b0;
    a_wr_addr = 5'd9; a_wr_data = 32'hC3;
    ard(0, 10); ard(1, 5);
    ex(0, 0, 0, 64'hBB, "x10_data");
    ex(0, 1, 0, 64'd0, "x10_busy");
    ex(0, 2, 0, 64'h200, "x9_still_busy");
    step();
    a_wr_en = 1'b0;
    ard(0, 9);
    ex(0, 0, 0, 64'hC3, "x9_data2");
    ex(0, 1, 0, 64'd0, "x9_one_release");
    ex(0, 2, 0, 64'd0, "busyvec_empty");

    // Bypass behaviour on x3
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h11;
    step();
    a_wr_data = 32'h22;
    ard(0, 3); ard(1, 2);
`ifdef REGFILE_BYPASS_EN
    byp = 32'h22;
`else
    byp = 32'h11;
`endif
    ex(0, 0, 0, {32'b0, byp}, "bypass_x3");
    ex(0, 1, 0, 64'd0, "bypass_busy");
    ex(0, 0, 1, 64'd512, "sp_intact");
    step();
    a_wr_en = 1'b0;
    ex(0, 0, 0, 64'h22, "x3_after");

    // Reset in the middle of activity on x4
    a_alloc_en = 1'b1; a_alloc_addr = 5'd4;
    step();
    a_rst = 1'b1;
    a_alloc_addr = 5'd6;
    a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h99;
    ard(0, 4);
    ex(0, 1, 0, 64'd1, "x4_busy_pre_rst");
    ex(0, 0, 0, 64'd0, "x4_data_pre_rst");
    step();
    a_rst = 1'b0; a_wr_en = 1'b0; a_alloc_en = 1'b0;
    ard(0, 4); ard(1, 2);
    ex(0, 0, 0, 64'd0, "x4_after_rst");
    ex(0, 0, 1, 64'd512, "sp_after_rst");
    ex(0, 2, 0, 64'd0, "busyvec_after_rst");
    step();
    ard(0, 5); ard(1, 3);
    ex(0, 0, 0, 64'd0, "x5_after_rst");
    ex(0, 0, 1, 64'd0, "x3_after_rst");

    // Wide instance basic test
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    brd(0, 2); brd(1, 0); brd(2, 15);
    ex(1, 0, 0, 64'd512, "b_rst_sp");
    ex(1, 0, 1, 64'd0, "b_rst_x0");
    ex(1, 0, 2, 64'd0, "b_rst_x15");
    ex(1, 2, 0, 64'd0, "b_rst_busyvec");
    b_wr_en = 1'b1; b_wr_addr = 4'd5;
    b_wr_data = 64'hDEADBEEF_CAFEF00D;
    b_alloc_en = 1'b1; b_alloc_addr = 4'd15;
    step();
    b_wr_en = 1'b0; b_alloc_en = 1'b0;
    brd(0, 5); brd(1, 5); brd(2, 15);
    ex(1, 0, 0, 64'hDEADBEEF_CAFEF00D, "b_x5_p0");
    ex(1, 0, 1, 64'hDEADBEEF_CAFEF00D, "b_x5_p1");
    ex(1, 1, 2, 64'd1, "b_x15_busy");
    ex(1, 2, 0, 64'h8000, "b_busyvec");
    step();
    b_wr_en = 1'b1; b_wr_addr = 4'd15;
    b_wr_data = 64'h0123_4567_89AB_CDEF;
    brd(2, 5);
    step();
    b_wr_en = 1'b0;
    brd(2, 15);
    ex(1, 0, 2, 64'h0123_4567_89AB_CDEF, "b_x15_data");
    ex(1, 1, 2, 64'd0, "b_x15_released");
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
